// File: rtl/way_replacement_ctrl_pkg.sv
// Shared definitions for the set-associative way controller.
//   state_t      : controller FSM states
//   log2()       : ceiling log2 for way-index widths (minimum 1)
//   DEF_*        : default geometry (4 ways, 20-bit tag, 64 sets)
package way_ctrl_pkg;

    localparam int unsigned DEF_WAYS    = 4;
    localparam int unsigned DEF_TAG_W   = 20;
    localparam int unsigned DEF_INDEX_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_RESP
    } state_t;

    function automatic int unsigned log2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/way_replacement_ctrl_victim_select.sv
// Combinational victim choice for one set.
//   valid       : valid bits of the set
//   lru         : one-hot LRU vector from the tracker (may be malformed)
//   way         : lowest invalid way, else lowest set bit of lru, else 0
//   was_invalid : the chosen way holds no valid line
module victim_select
    import way_ctrl_pkg::*;
#(
    parameter int unsigned WAYS = DEF_WAYS
) (
    input  logic [WAYS-1:0]       valid,
    input  logic [WAYS-1:0]       lru,
    output logic [log2(WAYS)-1:0] way,
    output logic                  was_invalid
);
    localparam int unsigned WAY_W = log2(WAYS);

    logic [WAY_W-1:0] invalid_way;
    logic [WAY_W-1:0] lru_way;
    logic             any_invalid;
    logic             any_lru;

    // Priority scans stop at the first hit so the lowest index wins; an
    // all-zero or multi-hot lru still resolves deterministically.
    always_comb begin
        invalid_way = '0;
        lru_way     = '0;
        any_invalid = 1'b0;
        any_lru     = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid[w[WAY_W-1:0]] && !any_invalid) begin
                any_invalid = 1'b1;
                invalid_way = w[WAY_W-1:0];
            end
            if (lru[w[WAY_W-1:0]] && !any_lru) begin
                any_lru = 1'b1;
                lru_way = w[WAY_W-1:0];
            end
        end
        was_invalid = any_invalid;
        way         = any_invalid ? invalid_way : lru_way;
    end

endmodule

// File: rtl/way_replacement_ctrl.sv
// Set-associative way controller upstream of the per-set LRU tracker.
// Owns tag/valid/dirty arrays, performs lookup, picks a victim on a miss and
// sequences writeback (evict_*) and refill (fill_*) handshakes. One request
// in flight at a time.
//   clock, reset        : rising-edge clock, synchronous active-low reset
//   req_*               : request valid/ready handshake with index, tag, write
//   resp_*              : one-cycle response pulse with hit flag and way
//   lru_in              : one-hot LRU vector of the requested set
//   lru_access(_valid)  : one-cycle touch pulse to the tracker
//   evict_*             : dirty-victim writeback valid/ready handshake
//   fill_*, fill_done   : refill request handshake and completion pulse
module way_replacement_ctrl
    import way_ctrl_pkg::*;
#(
    parameter int unsigned WAYS    = DEF_WAYS,
    parameter int unsigned TAG_W   = DEF_TAG_W,
    parameter int unsigned INDEX_W = DEF_INDEX_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_W-1:0]    req_index,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic                  req_write,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [log2(WAYS)-1:0] resp_way,
    input  logic [WAYS-1:0]       lru_in,
    output logic [log2(WAYS)-1:0] lru_access,
    output logic                  lru_access_valid,
    output logic                  evict_valid,
    input  logic                  evict_ready,
    output logic [INDEX_W-1:0]    evict_index,
    output logic [TAG_W-1:0]      evict_tag,
    output logic [log2(WAYS)-1:0] evict_way,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [INDEX_W-1:0]    fill_index,
    output logic [TAG_W-1:0]      fill_tag,
    input  logic                  fill_done
);
    localparam int unsigned WAY_W = log2(WAYS);
    localparam int unsigned SETS  = 1 << INDEX_W;

    state_t state, state_next;

    logic [INDEX_W-1:0] idx_q, idx_next;
    logic [TAG_W-1:0]   tag_q, tag_next;
    logic               write_q, write_next;
    logic [WAY_W-1:0]   way_q, way_next;
    logic               hit_q, hit_next;
    logic [TAG_W-1:0]   victim_tag_q, victim_tag_next;

    logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]    valid_mem [SETS];
    logic [WAYS-1:0]    dirty_mem [SETS];

    logic [WAYS-1:0]    set_valid;
    logic [WAYS-1:0]    set_dirty;
    logic [WAYS-1:0]    tag_match;
    logic               lookup_hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_way;
    logic               victim_invalid;
    logic               mark_dirty;
    logic               fill_commit;

    // Datapath outputs come straight from the latched request registers.
    assign evict_index = idx_q;
    assign evict_tag   = victim_tag_q;
    assign evict_way   = way_q;
    assign fill_index  = idx_q;
    assign fill_tag    = tag_q;
    assign resp_hit    = hit_q;
    assign resp_way    = way_q;
    assign lru_access  = way_q;

    always_comb begin
        set_valid  = valid_mem[idx_q];
        set_dirty  = dirty_mem[idx_q];
        tag_match  = '0;
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            tag_match[w[WAY_W-1:0]] = set_valid[w[WAY_W-1:0]] &&
                                      (tag_mem[idx_q][w[WAY_W-1:0]] == tag_q);
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (tag_match[w[WAY_W-1:0]] && !lookup_hit) begin
                lookup_hit = 1'b1;
                hit_way    = w[WAY_W-1:0];
            end
        end
    end

    victim_select #(
        .WAYS (WAYS)
    ) u_victim_select (
        .valid       (set_valid),
        .lru         (lru_in),
        .way         (victim_way),
        .was_invalid (victim_invalid)
    );

    always_comb begin
        state_next      = state;
        idx_next        = idx_q;
        tag_next        = tag_q;
        write_next      = write_q;
        way_next        = way_q;
        hit_next        = hit_q;
        victim_tag_next = victim_tag_q;
        mark_dirty      = 1'b0;
        fill_commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    idx_next   = req_index;
                    tag_next   = req_tag;
                    write_next = req_write;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    way_next   = hit_way;
                    hit_next   = 1'b1;
                    mark_dirty = write_q;
                    state_next = S_RESP;
                end else begin
                    way_next        = victim_way;
                    hit_next        = 1'b0;
                    victim_tag_next = tag_mem[idx_q][victim_way];
                    state_next      = (!victim_invalid && set_dirty[victim_way])
                                      ? S_EVICT : S_FILL_REQ;
                end
            end
            S_EVICT: begin
                if (evict_ready) state_next = S_FILL_REQ;
            end
            S_FILL_REQ: begin
                if (fill_ready) state_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (fill_done) begin
                    fill_commit = 1'b1;
                    state_next  = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= S_IDLE;
            idx_q            <= '0;
            tag_q            <= '0;
            write_q          <= 1'b0;
            way_q            <= '0;
            hit_q            <= 1'b0;
            victim_tag_q     <= '0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            lru_access_valid <= 1'b0;
            evict_valid      <= 1'b0;
            fill_valid       <= 1'b0;
        end else begin
            state            <= state_next;
            idx_q            <= idx_next;
            tag_q            <= tag_next;
            write_q          <= write_next;
            way_q            <= way_next;
            hit_q            <= hit_next;
            victim_tag_q     <= victim_tag_next;
            req_ready        <= (state_next == S_IDLE);
            resp_valid       <= (state_next == S_RESP);
            lru_access_valid <= (state_next == S_RESP);
            evict_valid      <= (state_next == S_EVICT);
            fill_valid       <= (state_next == S_FILL_REQ);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_mem[s[INDEX_W-1:0]] <= '0;
                dirty_mem[s[INDEX_W-1:0]] <= '0;
            end
        end else begin
            if (mark_dirty) dirty_mem[idx_q][hit_way] <= 1'b1;
            if (fill_commit) begin
                valid_mem[idx_q][way_q] <= 1'b1;
                dirty_mem[idx_q][way_q] <= write_q;
            end
        end
    end

    // Tags carry no reset; they are meaningless until the valid bit is set.
    always_ff @(posedge clock) begin
        if (reset && fill_commit) tag_mem[idx_q][way_q] <= tag_q;
    end

endmodule
